// File: rtl/mem_port_ctrl_if.sv
// Request/response and RAM-side signal bundle for mem_port_ctrl.
// slave = the controller; master = the load/store stage plus RAM that surround it.
interface mem_port_ctrl_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [2:0]  i_req_size;
   logic        i_req_sign;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_resp_valid;
   logic [31:0] o_resp_rdata;
   logic        o_resp_err;
   logic [31:0] o_mem_addr;
   logic [2:0]  o_mem_insize;
   logic        o_mem_insign;
   logic [2:0]  o_mem_outsize;
   logic [31:0] o_mem_data;
   logic [31:0] i_mem_data;

   modport slave (
      input  i_req_valid, i_req_we, i_req_size, i_req_sign, i_req_addr, i_req_wdata, i_mem_data,
      output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
      output o_mem_addr, o_mem_insize, o_mem_insign, o_mem_outsize, o_mem_data
   );

   modport master (
      output i_req_valid, i_req_we, i_req_size, i_req_sign, i_req_addr, i_req_wdata, i_mem_data,
      input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
      input  o_mem_addr, o_mem_insize, o_mem_insign, o_mem_outsize, o_mem_data
   );
endinterface

// File: rtl/mem_port_ctrl.sv
// Load/store port controller for the big-endian byte RAM; splits misaligned accesses into byte beats.
// Define MISALIGN_TRAP_EN to reject misaligned requests with err instead of splitting them.
module mem_port_ctrl #(
   parameter int unsigned LIMIT_BYTES = 0
) (
   input logic            i_clk,
   input logic            i_rst_n,
   mem_port_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] acc_q, acc_d;
   logic [2:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
`ifndef MISALIGN_TRAP_EN
   logic [1:0]  beat_q, beat_d;
   logic [2:0]  k;
   logic [31:0] shifted;
`endif
   logic        size_bad, range_bad, misaligned;
   logic [32:0] end_addr;

   always_comb begin
      size_bad   = !(bus.i_req_size inside {3'd1, 3'd2, 3'd4});
      end_addr   = {1'b0, bus.i_req_addr} + 33'(bus.i_req_size);
      range_bad  = (LIMIT_BYTES != 0) && (end_addr > 33'(LIMIT_BYTES));
      misaligned = ((bus.i_req_size == 3'd2) && bus.i_req_addr[0]) ||
                   ((bus.i_req_size == 3'd4) && (bus.i_req_addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      acc_d   = acc_q;
      size_d  = size_q;
      sign_d  = sign_q;
      we_d    = we_q;
      err_d   = err_q;
`ifndef MISALIGN_TRAP_EN
      beat_d  = beat_q;
      // beat_q counts down, so beat k = size-1-beat_q and the store byte index is beat_q
      k       = size_q - 3'd1 - {1'b0, beat_q};
      shifted = {acc_q[23:0], bus.i_mem_data[7:0]};
`endif
      bus.o_req_ready   = 1'b0;
      bus.o_resp_valid  = 1'b0;
      bus.o_resp_rdata  = '0;
      bus.o_resp_err    = 1'b0;
      bus.o_mem_addr    = '0;
      bus.o_mem_insize  = '0;
      bus.o_mem_insign  = 1'b0;
      bus.o_mem_outsize = '0;
      bus.o_mem_data    = '0;

      case (state_q)
         IDLE: begin
            bus.o_req_ready = 1'b1;
            if (bus.i_req_valid) begin
               addr_d  = bus.i_req_addr;
               wdata_d = bus.i_req_wdata;
               size_d  = bus.i_req_size;
               sign_d  = bus.i_req_sign;
               we_d    = bus.i_req_we;
               acc_d   = '0;
               err_d   = 1'b0;
               if (size_bad || range_bad) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
                  err_d   = 1'b1;
                  state_d = RESP;
`else
                  beat_d  = 2'(bus.i_req_size - 3'd1);
                  state_d = SPLIT;
`endif
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            bus.o_mem_addr = addr_q;
            if (we_q) begin
               bus.o_mem_outsize = size_q;
               bus.o_mem_data    = wdata_q;
               acc_d             = '0;
            end else begin
               bus.o_mem_insize = size_q;
               bus.o_mem_insign = sign_q;
               acc_d            = bus.i_mem_data;
            end
            state_d = RESP;
         end
`ifndef MISALIGN_TRAP_EN
         SPLIT: begin
            bus.o_mem_addr = addr_q + 32'(k);
            if (we_q) begin
               bus.o_mem_outsize = 3'd1;
               bus.o_mem_data    = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
            end else begin
               bus.o_mem_insize = 3'd1;
               acc_d            = shifted;
            end
            if (beat_q == 2'd0) begin
               if (!we_q && (size_q == 3'd2))
                  acc_d = {{16{sign_q & shifted[15]}}, shifted[15:0]};
               state_d = RESP;
            end else begin
               beat_d = beat_q - 2'd1;
            end
         end
`endif
         RESP: begin
            bus.o_resp_valid = 1'b1;
            bus.o_resp_rdata = acc_q;
            bus.o_resp_err   = err_q;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         acc_q   <= '0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
`ifndef MISALIGN_TRAP_EN
         beat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         acc_q   <= acc_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         we_q    <= we_d;
         err_q   <= err_d;
`ifndef MISALIGN_TRAP_EN
         beat_q  <= beat_d;
`endif
      end
   end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Initiator-side controller for the byte-addressed, big-endian data RAM; sits between the processor's load/store stage and the RAM.
- Accepts one load/store request at a time via valid/ready and drives the RAM's address/size/sign/data controls.
- Splits misaligned halfword/word accesses into byte beats, reassembles big-endian read data, sign-extends, and returns a single-cycle response.

Parameters:
- LIMIT_BYTES, 0: if nonzero, any access with addr+size > LIMIT_BYTES returns err with no RAM access; 0 disables the range check.

Ports:
- i_clk  in  1  clock; RAM writes on the same posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  controller can accept; high only in IDLE
- i_req_we  in  1  1=store, 0=load
- i_req_size  in  3  access bytes: 1, 2 or 4; other values illegal
- i_req_sign  in  1  sign-extend load result
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_resp_valid  out  1  one-cycle response pulse
- o_resp_rdata  out  32  load result; 0 for stores and errors
- o_resp_err  out  1  illegal size, range or misalignment error (with o_resp_valid)
- o_mem_addr  out  32  RAM byte address
- o_mem_insize  out  3  RAM read size (0 = none)
- o_mem_insign  out  1  RAM read sign-extend
- o_mem_outsize  out  3  RAM write size (0 = no write)
- o_mem_data  out  32  RAM write data
- i_mem_data  in  32  RAM combinational read data

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state IDLE, o_req_ready=1, o_resp_valid=0, o_resp_rdata=0, o_resp_err=0.
  - All o_mem_* = 0, so no RAM write can occur at the next edge.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: on i_req_valid & o_req_ready at a posedge, latch the request.
  - Illegal size (0, 3, 5, 6, 7) or range fail -> RESP with err=1.
  - Otherwise aligned (addr mod size == 0) -> ACCESS; misaligned -> SPLIT with beat counter = size-1.
- ACCESS (one cycle): o_mem_addr=addr.
  - Load: insize=size, insign=sign.
  - Store: outsize=size, data=wdata.
  - At the posedge, capture i_mem_data into the result register -> RESP.
- SPLIT (size cycles): beat k (0..size-1) uses o_mem_addr=addr+k with insize or outsize=1 and insign=0.
  - Store beat k drives byte (size-1-k) of wdata into o_mem_data[7:0]; the MSB byte goes to the lowest address (big-endian).
  - Load: acc <= {acc[23:0], i_mem_data[7:0]} each beat.
  - After the last beat, sign- or zero-extend from bit 8*size-1 -> RESP.
- RESP (one cycle): o_resp_valid=1 with rdata/err. o_mem_* sizes are 0. Then -> IDLE.
- Latency: o_resp_valid is asserted beats+1 cycles after the accepting edge.
  - Aligned: 2 cycles.
  - Misaligned word: 5 cycles.
  - Error: 1 cycle.
- Throughput: aligned back-to-back requests complete one every 3 cycles, since ready is low in ACCESS and RESP.
- Inputs: i_req_* are ignored while ready=0. No response backpressure; the upstream must take the pulse.
- Address wrap: addr+k is computed mod 2^32, with no carry-out detection unless LIMIT_BYTES is set.
- Stores: o_resp_rdata=0. Loads of size 4 ignore i_req_sign.
- Reset mid-SPLIT: abort. Any bytes already written stay written; no response is issued.

Optional Feature:
- MISALIGN_TRAP_EN defined: misaligned requests go directly to RESP with err=1. No RAM access occurs, and SPLIT logic is not generated.
- Undefined: misaligned requests are split as above.

Test Plan:
- RAM[0x10..0x13]=88 99 AA BB; load size 4 @0x10 -> resp 2 cycles after accept, rdata=0x8899AABB, err=0.
- Load size 2, sign=1 @0x10 -> 0xFFFF8899. Load size 1, sign=0 @0x13 -> 0x000000BB.
- RAM[0x11..0x14]=99 AA BB CC; load size 4 @0x11 -> four byte beats at addr 0x11..0x14, rdata=0x99AABBCC 5 cycles after accept. With MISALIGN_TRAP_EN -> err=1 after 1 cycle, no o_mem activity.
- Store size 4 wdata=0x11223344 @0x21 -> RAM[0x21..0x24]=11 22 33 44, neighbours untouched. Store size 2 @0x30 wdata=0xDEADBEEF -> RAM[0x30..0x31]=BE EF.
- size=3 request -> err=1, rdata=0, o_mem_outsize stays 0. LIMIT_BYTES=64, load size 4 @0x3E -> err=1.
- Assert i_rst_n low during beat 2 of a misaligned store -> ready=1 and all o_mem sizes 0 immediately; no o_resp_valid; bytes 0..1 already written.
